// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage.
//   op_e         : 2-bit adder/subtractor operation encoding
//   FLAG_*       : bit positions inside the 3-bit {N,Z,V} flag vector
//   op_is_sub()  : operation inverts B and injects a carry of 1
//   op_is_sat()  : operation saturates the result on signed overflow
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SADD = 2'b10,
        OP_SSUB = 2'b11
    } op_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    function automatic logic op_is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SSUB);
    endfunction

    function automatic logic op_is_sat(input logic [1:0] op);
        return (op == OP_SADD) || (op == OP_SSUB);
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit adder cell array with group propagate/generate outputs.
//   a, b : operand bits of this group (b is already inverted for subtract)
//   cin  : carry into the least significant bit of the group
//   s    : sum bits
//   p    : group propagate (every bit propagates)
//   g    : group generate (the group produces a carry on its own)
// p and g do not depend on cin, so the enclosing stage can resolve the
// carry into the next group without waiting for this group's sum bits.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] pb;
    logic [GROUP-1:0] gb;

    assign pb = a ^ b;
    assign gb = a & b;
    assign p  = &pb;

    // Cell chain inside the group: each cell passes its carry to the next.
    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < GROUP; i++) begin
            s[i] = pb[i] ^ c;
            c    = gb[i] | (pb[i] & c);
        end
    end

    // Group generate: a carry leaves the MSB with cin = 0.
    always_comb begin
        g = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            g = gb[i] | (pb[i] & g);
        end
    end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with optional signed saturation.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : kills every in-flight operation at the next edge
//   in_valid/in_ready : operand handshake (a, b, op)
//   op                : 00 ADD, 01 SUB, 10 SADD, 11 SSUB
//   out_valid/out_ready : result handshake (result, cout, flags)
//   result            : sum/difference, saturated in the S* modes
//   cout              : raw carry out of the MSB (SUB: 1 = no borrow)
//   flags             : {N,Z,V}; V is the signed overflow before saturation
// The WIDTH/GROUP lookahead groups are split evenly across PIPE_STAGES
// stages. Each non-final stage carries its finished sum bits forward
// together with the operand bits still to be added and the carry into
// them. The final stage's register is the output register.
// WIDTH must be a multiple of GROUP and the group count a multiple of
// PIPE_STAGES.
module cla_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int GROUP       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [2:0]       flags
);

    localparam int NGROUPS = WIDTH / GROUP;
    localparam int GPS     = NGROUPS / PIPE_STAGES;  // groups per stage
    localparam int SBITS   = GPS * GROUP;            // sum bits per stage

    logic accept;

    assign in_ready = !rst && !flush && stg[0].ready;
    assign accept   = in_valid && in_ready;

    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : stg
        localparam int LO   = gi * SBITS;   // first bit resolved here
        localparam int DONE = LO + SBITS;   // bits finished after this stage

        logic                valid_reg;
        logic                ready;     // this stage's register can load
        logic                v_in;
        logic [WIDTH-1:LO]   a_in;
        logic [WIDTH-1:LO]   bp_in;
        logic                c_in;
        logic [1:0]          op_in;
        logic [SBITS-1:0]    s_stage;
        logic [DONE-1:0]     sum_next;
        logic                c_out;

        // Stage inputs: operand ports for the head, previous register otherwise.
        if (gi == 0) begin : src
            assign a_in     = a;
            assign bp_in    = op_is_sub(op) ? ~b : b;
            assign c_in     = op_is_sub(op);
            assign op_in    = op;
            assign v_in     = accept;
            assign sum_next = s_stage;
        end else begin : src
            assign a_in     = stg[gi-1].mid.a_reg;
            assign bp_in    = stg[gi-1].mid.bp_reg;
            assign c_in     = stg[gi-1].mid.c_reg;
            assign op_in    = stg[gi-1].mid.op_reg;
            assign v_in     = stg[gi-1].valid_reg;
            assign sum_next = {s_stage, stg[gi-1].mid.sum_reg};
        end

        // Group-level lookahead: c[i+1] = G_i | P_i & c[i].
        for (genvar gj = 0; gj < GPS; gj++) begin : grp
            logic ci;
            logic gp;
            logic gg;
            logic co;

            if (gj == 0) begin : cfirst
                assign ci = c_in;
            end else begin : cnext
                assign ci = grp[gj-1].co;
            end

            cla_group #(
                .GROUP (GROUP)
            ) u_grp (
                .a   (a_in[LO + gj*GROUP +: GROUP]),
                .b   (bp_in[LO + gj*GROUP +: GROUP]),
                .cin (ci),
                .s   (s_stage[gj*GROUP +: GROUP]),
                .p   (gp),
                .g   (gg)
            );

            assign co = gg | (gp & ci);
        end

        assign c_out = grp[GPS-1].co;

        // Valid bits are the only control state; a stage accepts whenever it
        // is empty or its content is leaving, so bubbles collapse.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                valid_reg <= 1'b0;
            end else if (ready) begin
                valid_reg <= v_in;
            end
        end

        if (gi < PIPE_STAGES - 1) begin : mid
            logic [WIDTH-1:DONE] a_reg;
            logic [WIDTH-1:DONE] bp_reg;
            logic [DONE-1:0]     sum_reg;
            logic                c_reg;
            logic [1:0]          op_reg;

            assign ready = !valid_reg || stg[gi+1].ready;

            always_ff @(posedge clk) begin
                if (ready && v_in) begin
                    a_reg   <= a_in[WIDTH-1:DONE];
                    bp_reg  <= bp_in[WIDTH-1:DONE];
                    sum_reg <= sum_next;
                    c_reg   <= c_out;
                    op_reg  <= op_in;
                end
            end
        end else begin : fin
            logic [WIDTH-1:0] raw;
            logic [WIDTH-1:0] res_next;
            logic [2:0]       flags_next;
            logic             v_ovf;
            logic             sat;
            logic [WIDTH-1:0] result_reg;
            logic             cout_reg;
            logic [2:0]       flags_reg;

            assign ready = !valid_reg || out_ready;
            assign raw   = sum_next;

            // Overflow: operands agree in sign but the raw sum does not.
            assign v_ovf = (a_in[WIDTH-1] == bp_in[WIDTH-1]) &&
                           (raw[WIDTH-1] != a_in[WIDTH-1]);
            assign sat   = op_is_sat(op_in) && v_ovf;

            // On overflow the true result lies beyond the range on A's side.
            assign res_next = sat ? {a_in[WIDTH-1], {(WIDTH-1){~a_in[WIDTH-1]}}}
                                  : raw;

            always_comb begin
                flags_next         = '0;
                flags_next[FLAG_N] = res_next[WIDTH-1];
                flags_next[FLAG_Z] = (res_next == '0);
                flags_next[FLAG_V] = v_ovf;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    result_reg <= '0;
                    cout_reg   <= 1'b0;
                    flags_reg  <= '0;
                end else if (!flush && ready && v_in) begin
                    result_reg <= res_next;
                    cout_reg   <= c_out;
                    flags_reg  <= flags_next;
                end
            end
        end
    end

    assign out_valid = stg[PIPE_STAGES-1].valid_reg;
    assign result    = stg[PIPE_STAGES-1].fin.result_reg;
    assign cout      = stg[PIPE_STAGES-1].fin.cout_reg;
    assign flags     = stg[PIPE_STAGES-1].fin.flags_reg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=16, GROUP=4, PIPE_STAGES=2).
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    cla_addsub_pipe #(
        .WIDTH       (16),
        .GROUP       (4),
        .PIPE_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        co;
        logic [2:0]  fl;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          issued;
        int          popped;
        int          cyc;
        int          pat [6];
        bit          m_v0;
        bit          m_v1;
        bit          r0;
        bit          r1;
        bit          acc;
        logic [15:0] se;
        logic [15:0] expq [$];

        // {op, a, b, result, cout, {N,Z,V}}
        vecs[0]  = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 3'b101};
        vecs[1]  = '{2'b10, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 3'b001};
        vecs[2]  = '{2'b11, 16'h8000, 16'h0001, 16'h8000, 1'b1, 3'b101};
        vecs[3]  = '{2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b1, 3'b010};
        vecs[4]  = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3'b010};
        vecs[5]  = '{2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 3'b000};
        vecs[6]  = '{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 3'b100};
        vecs[7]  = '{2'b10, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 3'b101};
        vecs[8]  = '{2'b11, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 3'b001};
        vecs[9]  = '{2'b00, 16'h1234, 16'h1111, 16'h2345, 1'b0, 3'b000};
        vecs[10] = '{2'b10, 16'h0001, 16'h0002, 16'h0003, 1'b0, 3'b000};
        vecs[11] = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 3'b100};
        vecs[12] = '{2'b00, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 3'b000};
        vecs[13] = '{2'b11, 16'h8000, 16'h8000, 16'h0000, 1'b1, 3'b010};
        pat = '{1, 0, 0, 1, 0, 1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = 2'b00;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result",    32'(result),    32'd0);
        chk("reset_cout",      32'(cout),      32'd0);
        chk("reset_flags",     32'(flags),     32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        step();

        // Directed vectors, one at a time, exact two-cycle latency.
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            step();
            in_valid = 1'b0;
            chk("vec_latency_early", 32'(out_valid), 32'd0);
            step();
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_result",    32'(result),    32'(vecs[i].res));
            chk("vec_cout",      32'(cout),      32'(vecs[i].co));
            chk("vec_flags",     32'(flags),     32'(vecs[i].fl));
            $display("vec %0d op=%0d a=%h b=%h -> result=%h cout=%0d flags=%b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, result, cout, flags);
        end
        step();

        // Back-to-back stream with a stalling consumer.
        issued = 0; popped = 0; cyc = 0; m_v0 = 1'b0; m_v1 = 1'b0;
        while (popped < 10 && cyc < 300) begin
            in_valid  = (issued < 10);
            a         = 16'(issued * 32'h1111);
            b         = 16'(32'h0123 + issued);
            op        = (issued % 2 == 1) ? 2'b01 : 2'b00;
            out_ready = (pat[cyc % 6] != 0);
            #1;
            r1 = !m_v1 || out_ready;
            r0 = !m_v0 || r1;
            chk("stream_in_ready",  32'(in_ready),  32'(r0));
            chk("stream_out_valid", 32'(out_valid), 32'(m_v1));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("stream_extra", 32'(result), 32'hFFFF_FFFF);
                end else begin
                    chk("stream_result", 32'(result), 32'(expq[0]));
                    $display("stream out %0d result=%h", popped, result);
                    void'(expq.pop_front());
                end
                popped++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                se = (op == 2'b01) ? (a - b) : (a + b);
                expq.push_back(se);
                issued++;
            end
            m_v1 = r1 ? m_v0 : m_v1;
            m_v0 = r0 ? acc : m_v0;
            cyc++;
            step();
        end
        chk("stream_count", 32'(popped), 32'd10);
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        // Flush with two ops in flight and a simultaneous (dropped) request.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 2'b00; a = 16'h0001; b = 16'h0002;
        step();
        a = 16'h0003; b = 16'h0004;
        step();
        chk("flush_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; a = 16'h00AA; b = 16'h0011;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; out_ready = 1'b1; a = 16'h0F0F; b = 16'h0101;
        #1;
        chk("flush_out_valid",  32'(out_valid), 32'd0);
        chk("flush_in_ready_1", 32'(in_ready),  32'd1);
        step();
        in_valid = 1'b0;
        chk("flush_gap", 32'(out_valid), 32'd0);
        step();
        chk("flush_new_valid",  32'(out_valid), 32'd1);
        chk("flush_new_result", 32'(result),    32'h1010);
        $display("post-flush op result=%h", result);
        step();
        chk("flush_no_extra", 32'(out_valid), 32'd0);

        // Reset with two ops in flight and a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 2'b00; a = 16'h1000; b = 16'h0001;
        step();
        a = 16'h2000; b = 16'h0002;
        step();
        chk("rst_pre_result", 32'(result), 32'h1001);
        in_valid = 1'b0; rst = 1'b1;
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        in_valid = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h1111; out_ready = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        chk("rst_new_valid",  32'(out_valid), 32'd1);
        chk("rst_new_result", 32'(result),    32'h2345);
        chk("rst_new_flags",  32'(flags),     32'd0);
        $display("post-reset op result=%h", result);
        step();
        chk("rst_no_extra", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
